// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first, one bit per clock).
// Optional signed-overflow output `ovf` is enabled by defining SERSUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrowout
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Full-subtractor cell: returns {borrow_out, diff_bit}
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
        return {((~x & (y ^ bin)) | (y & bin)), (x ^ y ^ bin)};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] sr_nxt_s;
    logic             br_r;
    logic             br_nxt_s;
    logic             d_s;
    logic [1:0]       cell_s;
    logic [CW-1:0]    cnt_r;
    logic             last_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrowout_r;
`ifdef SERSUB_OVF_EN
    logic             a_msb_r;
    logic             b_msb_r;
    logic             ovf_r;
`endif

    assign cell_s   = full_sub(sa_r[0], sb_r[0], br_r);
    assign d_s      = cell_s[0];
    assign br_nxt_s = cell_s[1];
    assign sr_nxt_s = WIDTH'({d_s, sr_r} >> 1'b1);
    assign last_s   = (cnt_r == CNT_LAST);

    assign busy      = busy_r;
    assign done      = done_r;
    assign diff      = diff_r;
    assign borrowout = borrowout_r;
`ifdef SERSUB_OVF_EN
    assign ovf       = ovf_r;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; start is only honoured in IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand shifters, borrow chain, counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa_r        <= {WIDTH{1'b0}};
            sb_r        <= {WIDTH{1'b0}};
            sr_r        <= {WIDTH{1'b0}};
            br_r        <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            diff_r      <= {WIDTH{1'b0}};
            borrowout_r <= 1'b0;
`ifdef SERSUB_OVF_EN
            a_msb_r     <= 1'b0;
            b_msb_r     <= 1'b0;
            ovf_r       <= 1'b0;
`endif
        end else begin
            busy_r <= (state_nxt_s == SHIFT);
            done_r <= (state_nxt_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sa_r    <= a;
                        sb_r    <= b;
                        sr_r    <= {WIDTH{1'b0}};
                        br_r    <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
`ifdef SERSUB_OVF_EN
                        a_msb_r <= a[WIDTH-1];
                        b_msb_r <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
                    sr_r  <= sr_nxt_s;
                    br_r  <= br_nxt_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    // Results are published only on the edge that enters DONE
                    if (last_s) begin
                        diff_r      <= sr_nxt_s;
                        borrowout_r <= br_nxt_s;
`ifdef SERSUB_OVF_EN
                        ovf_r       <= (a_msb_r ^ b_msb_r) & (sr_nxt_s[WIDTH-1] ^ a_msb_r);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed and random operations checked
// against an arithmetic reference model (ovf checked when SERSUB_OVF_EN is defined).
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int MASK  = (1 << WIDTH) - 1;
    localparam int SMAX  = (1 << (WIDTH - 1)) - 1;
    localparam int SMIN  = -(1 << (WIDTH - 1));

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrowout;
`ifdef SERSUB_OVF_EN
    logic             ovf;
`endif

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .diff(diff),
        .borrowout(borrowout)
`ifdef SERSUB_OVF_EN
        ,
        .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int n0;   // cycle index (negedge count) of the first busy cycle
        int d;
        int bo;
        int ov;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   exp_busy;
    bit   exp_done;
    int   last_d = 0;
    int   last_bo = 0;
    int   last_ov = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference: modular difference, unsigned compare for borrow, signed range for overflow
    function automatic exp_t model(input int av, input int bv, input int n0);
        exp_t e;
        int   sa;
        int   sbv;
        sa    = (av > SMAX) ? av - (1 << WIDTH) : av;
        sbv   = (bv > SMAX) ? bv - (1 << WIDTH) : bv;
        e.n0  = n0;
        e.d   = (av - bv) & MASK;
        e.bo  = (av < bv) ? 1 : 0;
        e.ov  = ((sa - sbv) > SMAX || (sa - sbv) < SMIN) ? 1 : 0;
        return e;
    endfunction

    task automatic start_op(input int av, input int bv);
        start = 1'b1;
        a     = av[WIDTH-1:0];
        b     = bv[WIDTH-1:0];
        sb.push_back(model(av, bv, cyc + 1));
        tick();
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
    endtask

    task automatic run_op(input int av, input int bv);
        start_op(av, bv);
        repeat (WIDTH + 1) tick();
    endtask

    task automatic stray_start();
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        sb.delete();
        last_d  = 0;
        last_bo = 0;
        last_ov = 0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrowout", borrowout, 0);
`ifdef SERSUB_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
    endtask

    // Monitor: derives expected busy/done timing and held results from the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            if (sb.size() > 0) begin
                exp_busy = (cyc >= sb[0].n0) && (cyc < sb[0].n0 + WIDTH);
                exp_done = (cyc == sb[0].n0 + WIDTH);
            end
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("busy_done_excl", busy & done, 0);
            if (exp_done) begin
                mon_e   = sb.pop_front();
                last_d  = mon_e.d;
                last_bo = mon_e.bo;
                last_ov = mon_e.ov;
            end
            chk("diff", diff, last_d);
            chk("borrowout", borrowout, last_bo);
`ifdef SERSUB_OVF_EN
            chk("ovf", ovf, last_ov);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        do_reset();
        mon_en = 1'b1;
        tick();

        run_op(8'h05, 8'h03);
        run_op(8'h03, 8'h05);
        run_op(8'h00, 8'hFF);
        run_op(8'h80, 8'h01);
        run_op(8'h10, 8'h01);

        // Requests during SHIFT and DONE must be dropped
        start_op(8'h09, 8'h04);
        repeat (2) tick();
        stray_start();
        repeat (5) tick();
        stray_start();
        repeat (3) tick();

        // Reset in the middle of an operation aborts it
        start_op(8'h55, 8'h22);
        repeat (3) tick();
        do_reset();
        repeat (WIDTH + 3) tick();
        run_op(8'h55, 8'h22);

        // Back-to-back on the first IDLE cycle after done
        run_op(8'hAA, 8'h55);
        run_op(8'h00, 8'h00);

        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (4) tick();
        chk("pending_results", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
